div_seq: RTL and testbench

Multi-cycle sequencer for 32-bit signed/unsigned integer division in the execute stage. It accepts one operation through a start/annul handshake and runs a restoring shift-subtract loop that produces one quotient bit per cycle. It holds the pipeline with a stall request until the result is ready, then keeps quotient and remainder stable for writeback to HI/LO. Multiply/logic paths stay combinational in the execute stage; only division is sequenced here.

---
 rtl/div_seq_pkg.sv | 14 +
 rtl/div_seq_if.sv | 19 +
 rtl/div_seq.sv | 71 +++++++
 tb/tb_div_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encodings and handshake constants for the divide sequencer
package div_seq_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0;
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: execute-stage <-> divider handshake bundle
interface div_seq_if #(parameter int DW = 32) ();
  logic          signed_div_i;
  logic [DW-1:0] opdata1_i;
  logic [DW-1:0] opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*DW-1:0] result_o;
  logic          ready_o;
  logic          stall_req_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stall_req_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stall_req_o
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: restoring shift-subtract divider, one quotient bit per cycle, result held until start drops
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(DW) + 1;
  div_state_e      r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2*DW-1:0] r_work, r_result;
  logic [DW-1:0]   r_dvs;
  logic            r_sa, r_sb;
  logic [DW:0]     w_diff;
  logic            w_go, w_done, w_ready, w_na, w_nb;
  logic [DW-1:0]   w_a, w_b, w_q, w_r;
  assign w_go    = (bus.start_i == DivStart) && !bus.annul_i;
  assign w_done  = r_cnt == CW'(DW);
  assign w_na    = bus.signed_div_i && bus.opdata1_i[DW-1];
  assign w_nb    = bus.signed_div_i && bus.opdata2_i[DW-1];
  assign w_a     = w_na ? -bus.opdata1_i : bus.opdata1_i;
  assign w_b     = w_nb ? -bus.opdata2_i : bus.opdata2_i;
  // high half plus next dividend bit can exceed DW bits; MSB of the DW+1 difference is the borrow
  assign w_diff  = r_work[2*DW-1:DW-1] - {1'b0, r_dvs};
  assign w_q     = (r_sa ^ r_sb) ? -r_work[DW-1:0] : r_work[DW-1:0];
  assign w_r     = r_sa ? -r_work[2*DW-1:DW] : r_work[2*DW-1:DW];
  assign w_ready = (r_state == DivEnd) ? DivResultReady : DivResultNotReady;
  assign bus.ready_o     = w_ready;
  assign bus.result_o    = r_result;
  assign bus.stall_req_o = w_go && !w_ready;
  always_ff @(posedge clk) begin
    if (rst) r_state <= DivFree;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      DivFree:   w_next = !w_go ? DivFree : (bus.opdata2_i == DW'(ZeroWord)) ? DivByZero : DivOn;
      DivByZero: w_next = DivEnd;
      DivOn:     w_next = bus.annul_i ? DivFree : w_done ? DivEnd : DivOn;
      DivEnd:    w_next = (bus.start_i == DivStop) ? DivFree : DivEnd;
      default:   w_next = DivFree;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_work   <= '0;
      r_dvs    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_result <= '0;
    end else begin
      if (r_state == DivFree && w_next == DivOn) begin
        r_cnt  <= '0;
        r_work <= {{DW{1'b0}}, w_a};
        r_dvs  <= w_b;
        r_sa   <= w_na;
        r_sb   <= w_nb;
      end else if (r_state == DivOn && !bus.annul_i && !w_done) begin
        r_cnt  <= r_cnt + CW'(1);
        r_work <= w_diff[DW] ? {r_work[2*DW-2:0], 1'b0} : {w_diff[DW-1:0], r_work[DW-2:0], 1'b1};
      end
      if (r_state == DivByZero || (r_state == DivEnd && w_next == DivFree)) r_result <= '0;
      else if (r_state == DivOn && w_next == DivEnd) r_result <= {w_r, w_q};
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against a transaction-level reference model
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic armed = 1'b0;
  int total = 0;
  int bad = 0;
  div_seq_if #(.DW(32)) bus ();
  div_seq #(.DW(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction
  // quotient truncates toward zero, remainder takes the dividend's sign; x/0 gives 0
  function automatic logic [63:0] ref_div(logic s, logic [31:0] a, logic [31:0] b);
    longint x, y;
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    q = 32'(x / y);
    r = 32'(x % y);
    return {r, q};
  endfunction
  int          cd = 0;
  logic        zpend = 1'b0;
  logic [63:0] pend = '0;
  logic        exp_ready = 1'b0;
  logic [63:0] exp_res = '0;
  // edges remaining until the result appears: 33 after acceptance, 1 for a zero divisor
  always @(posedge clk) begin
    if (rst) begin
      cd <= 0;
      exp_ready <= 1'b0;
      exp_res <= '0;
    end else if (exp_ready) begin
      if (!bus.start_i) begin
        exp_ready <= 1'b0;
        exp_res <= '0;
      end
    end else if (cd > 0) begin
      if (bus.annul_i && !zpend) cd <= 0;
      else begin
        cd <= cd - 1;
        if (cd == 1) begin
          exp_ready <= 1'b1;
          exp_res <= pend;
        end
      end
    end else if (bus.start_i && !bus.annul_i) begin
      pend  <= ref_div(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
      zpend <= bus.opdata2_i == 32'h0;
      cd    <= (bus.opdata2_i == 32'h0) ? 1 : 33;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("ready", {63'b0, bus.ready_o}, {63'b0, exp_ready});
      chk("result", bus.result_o, exp_res);
      chk("stall", {63'b0, bus.stall_req_o}, {63'b0, bus.start_i && !bus.annul_i && !exp_ready});
    end
  end
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold,
                     input int ann, output logic [63:0] got, output int edges, output int stalls);
    @(posedge clk);
    #2;
    bus.signed_div_i = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b0;
    edges = 0;
    stalls = 0;
    got = '0;
    while (1) begin
      @(negedge clk);
      if (bus.stall_req_o) stalls++;
      if (bus.ready_o) begin
        got = bus.result_o;
        break;
      end
      if (edges >= 60 || (ann >= 0 && edges > ann + 2)) break;
      @(posedge clk);
      #2;
      edges++;
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      bus.signed_div_i = 1'($urandom);
      if (edges == ann) bus.annul_i = 1'b1;
      else if (bus.annul_i) begin
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
      end
    end
    if (!bus.ready_o && ann < 0) begin
      total++;
      bad++;
      $display("FAIL timeout got=no_ready exp=ready_within_60");
    end
    if (bus.ready_o) begin
      repeat (hold) begin
        @(posedge clk);
        #2;
      end
      bus.start_i = 1'b0;
      @(posedge clk);
      #2;
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] g;
    int e, st;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(posedge clk);
    #2 armed = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    chk("pin_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    chk("pin_m7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("pin_7_m2", ref_div(1'b1, 32'd7, 32'hFFFF_FFFE), {32'd1, 32'hFFFF_FFFD});
    chk("pin_min_m1", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
    run(1'b0, 32'd100, 32'd7, 0, -1, g, e, st);
    chk("udiv_100_7", g, {32'd2, 32'd14});
    chk("lat_normal", 64'(e), 64'd34);
    chk("stall_cycles", 64'(st), 64'd34);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 1, -1, g, e, st);
    chk("sdiv_m7_2", g, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 0, -1, g, e, st);
    chk("sdiv_7_m2", g, {32'd1, 32'hFFFF_FFFD});
    run(1'b0, 32'd12345, 32'd0, 0, -1, g, e, st);
    chk("div0_res", g, 64'h0);
    chk("lat_div0", 64'(e), 64'd2);
    chk("stall_div0", 64'(st), 64'd2);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, g, e, st);
    chk("sdiv_min_m1", g, {32'd0, 32'h8000_0000});
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, g, e, st);
    chk("udiv_min_m1", g, {32'h8000_0000, 32'd0});
    run(1'b0, 32'd1000, 32'd3, 0, 11, g, e, st);
    chk("annul_noready", {63'b0, bus.ready_o}, 64'h0);
    run(1'b0, 32'd50, 32'd5, 5, -1, g, e, st);
    chk("after_annul", g, {32'd0, 32'd10});
    @(negedge clk);
    chk("end_clear_res", bus.result_o, 64'h0);
    chk("end_clear_rdy", {63'b0, bus.ready_o}, 64'h0);
    @(posedge clk);
    #2;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.opdata2_i = 32'd3;
    repeat (3) begin
      @(negedge clk);
      chk("annul_free_stall", {63'b0, bus.stall_req_o}, 64'h0);
    end
    #2;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(posedge clk);
    #2;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_res", bus.result_o, 64'h0);
    chk("rst_mid_rdy", {63'b0, bus.ready_o}, 64'h0);
    chk("rst_mid_stall", {63'b0, bus.stall_req_o}, 64'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic s;
      logic [31:0] a, b;
      int ann;
      s = 1'($urandom);
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      ann = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : -1;
      run(s, a, b, int'($urandom_range(0, 3)), ann, g, e, st);
      if (ann < 0) chk("rand_res", g, ref_div(s, a, b));
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
